fifo_burst_reader: RTL and testbench

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_reader_pkg.sv | 18 +
 rtl/fifo_burst_reader.sv | 108 ++++++++++
 tb/tb_fifo_burst_reader.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_reader_pkg.sv
// ============================================================================
// Module : fifo_reader_pkg
// Brief  : Shared types for the FIFO burst reader (FSM state encoding).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage : fifo_reader_pkg

`default_nettype wire

// File: rtl/fifo_burst_reader.sv
// ============================================================================
// Module : fifo_burst_reader
// Brief  : Pops a requested number of words from a FWFT sync FIFO and
//          presents them on a registered valid/ready output with a last flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_burst_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int MAXBURST  = 16,
    localparam int LENWIDTH = $clog2(MAXBURST + 1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [LENWIDTH-1:0]  burst_len,
    input  logic                 abort,
    input  logic                 fifo_empty,
    input  logic [DATAWIDTH-1:0] fifo_read_data,
    output logic                 fifo_read_en,
    output logic                 out_valid,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);

    localparam logic [LENWIDTH-1:0] c_MAX_LEN = LENWIDTH'(MAXBURST);
    localparam logic [LENWIDTH-1:0] c_ONE     = LENWIDTH'(1);

    state_t                r_state;
    logic [LENWIDTH-1:0]   r_remaining;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [DATAWIDTH-1:0]  r_out_data;

    logic                  w_pop;
    logic                  w_accept;
    logic                  w_start_ok;

    // Pop only when the output slot is free or being emptied this edge;
    // abort suppresses the pop so no FIFO word is lost on a cancelled burst.
    assign w_pop      = (r_state == READ) && !fifo_empty &&
                        (!r_out_valid || out_ready) && !abort;
    assign w_accept   = r_out_valid && out_ready;
    assign w_start_ok = start && (burst_len != '0) && (burst_len <= c_MAX_LEN);

    assign fifo_read_en = w_pop;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_last     = r_out_last;
    assign busy         = (r_state != IDLE);
    assign done         = (r_state == DRAIN) && w_accept && r_out_last && !abort;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (abort) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_out_data  <= fifo_read_data;
                r_out_valid <= 1'b1;
                r_out_last  <= (r_remaining == c_ONE);
                r_remaining <= r_remaining - c_ONE;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end

            // READ is only entered with a non-zero count and left on the
            // pop that reaches zero, so the counter cannot wrap.
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_remaining <= burst_len;
                        r_state     <= READ;
                    end
                end
                READ: begin
                    if (w_pop && (r_remaining == c_ONE)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_accept && r_out_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : fifo_burst_reader

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// ============================================================================
// Module : tb_fifo_burst_reader
// Brief  : Directed self-checking bench for fifo_burst_reader with a FWFT
//          FIFO model and an output acceptance monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_burst_reader;

    localparam int DW = 32;
    localparam int MB = 16;
    localparam int LW = $clog2(MB + 1);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          abort = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_read_data;
    logic          fifo_read_en;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATAWIDTH(DW), .MAXBURST(MB)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start          (start),
        .burst_len      (burst_len),
        .abort          (abort),
        .fifo_empty     (fifo_empty),
        .fifo_read_data (fifo_read_data),
        .fifo_read_en   (fifo_read_en),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_ready      (out_ready),
        .busy           (busy),
        .done           (done)
    );

    // FWFT FIFO model: writes from the stimulus side, reads from the monitor.
    logic [DW-1:0] mem [256];
    logic [7:0]    wr_ptr = '0;
    logic [7:0]    rd_ptr = '0;
    logic          flush_req = 1'b0;

    assign fifo_empty     = (wr_ptr == rd_ptr);
    assign fifo_read_data = mem[rd_ptr];

    int            pop_cnt  = 0;
    int            done_cnt = 0;
    int            bad_en   = 0;
    logic [DW-1:0] rx_data [$];
    logic          rx_last [$];

    always @(posedge clk) begin
        if (fifo_read_en && fifo_empty) bad_en <= bad_en + 1;
        if (flush_req)         rd_ptr <= wr_ptr;
        else if (fifo_read_en) rd_ptr <= rd_ptr + 8'd1;
        if (fifo_read_en) pop_cnt <= pop_cnt + 1;
        if (done)         done_cnt <= done_cnt + 1;
        if (out_valid && out_ready) begin
            rx_data.push_back(out_data);
            rx_last.push_back(out_last);
        end
    end

    task automatic push(input logic [DW-1:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic flush();
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({out_valid, out_last, done, busy, fifo_read_en} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got v=%b l=%b d=%b b=%b en=%b expected all 0",
                     out_valid, out_last, done, busy, fifo_read_en);
        end
        tests++;
        if (out_data !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h expected 0", out_data);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic(input string tag);
        logic [DW-1:0] w [4];
        int pb, db;
        w = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C, 32'hD000_000D};
        for (int i = 0; i < 4; i++) push(w[i]);
        out_ready = 1'b1;
        pb = pop_cnt; db = done_cnt;
        @(negedge clk); start = 1'b1; burst_len = LW'(4);
        @(negedge clk); start = 1'b0;
        tests++;
        if ({busy, fifo_read_en, out_valid} !== 3'b110) begin
            fails++;
            $display("FAIL %s_n1: got busy/en/valid=%b expected 110", tag, {busy, fifo_read_en, out_valid});
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || out_data !== w[k] || out_last !== (k == 3) || done !== (k == 3)) begin
                fails++;
                $display("FAIL %s_word%0d: got v=%b d=%h l=%b done=%b expected v=1 d=%h l=%b done=%b",
                         tag, k, out_valid, out_data, out_last, done, w[k], k == 3, k == 3);
            end
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL %s_end: got v=%b busy=%b done=%b expected 0 0 0", tag, out_valid, busy, done);
        end
        tests++;
        if (pop_cnt - pb !== 4 || done_cnt - db !== 1) begin
            fails++;
            $display("FAIL %s_counts: got pops=%0d dones=%0d expected 4 1", tag, pop_cnt - pb, done_cnt - db);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w [4];
        int pb, db, rb;
        w = '{32'h1111_0001, 32'h1111_0002, 32'h1111_0003, 32'h1111_0004};
        for (int i = 0; i < 4; i++) push(w[i]);
        pb = pop_cnt; db = done_cnt; rb = rx_data.size();
        out_ready = 1'b0;
        @(negedge clk); start = 1'b1; burst_len = LW'(3);
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || out_data !== w[0] || out_last !== 1'b0 || fifo_read_en !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d: got v=%b d=%h l=%b en=%b expected v=1 d=%h l=0 en=0",
                         k, out_valid, out_data, out_last, fifo_read_en, w[0]);
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || rx_data.size() - rb !== 3) begin
            fails++;
            $display("FAIL bp_complete: got busy=%b words=%0d expected busy=0 words=3", busy, rx_data.size() - rb);
        end else begin
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (rx_data[rb+k] !== w[k] || rx_last[rb+k] !== (k == 2)) begin
                    fails++;
                    $display("FAIL bp_order%0d: got %h last=%b expected %h last=%b",
                             k, rx_data[rb+k], rx_last[rb+k], w[k], k == 2);
                end
            end
        end
        tests++;
        if (pop_cnt - pb !== 3 || done_cnt - db !== 1) begin
            fails++;
            $display("FAIL bp_counts: got pops=%0d dones=%0d expected 3 1", pop_cnt - pb, done_cnt - db);
        end
        flush();
    endtask

    task automatic test_underflow();
        logic [DW-1:0] w [5];
        int pb, db, rb;
        w = '{32'h2222_0001, 32'h2222_0002, 32'h2222_0003, 32'h2222_0004, 32'h2222_0005};
        push(w[0]); push(w[1]);
        pb = pop_cnt; db = done_cnt; rb = rx_data.size();
        out_ready = 1'b1;
        @(negedge clk); start = 1'b1; burst_len = LW'(5);
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        tests++;
        if (busy !== 1'b1 || fifo_read_en !== 1'b0 || rx_data.size() - rb !== 2 || done_cnt - db !== 0) begin
            fails++;
            $display("FAIL uf_stall: got busy=%b en=%b words=%0d dones=%0d expected 1 0 2 0",
                     busy, fifo_read_en, rx_data.size() - rb, done_cnt - db);
        end
        push(w[2]); push(w[3]); push(w[4]);
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || rx_data.size() - rb !== 5) begin
            fails++;
            $display("FAIL uf_complete: got busy=%b words=%0d expected busy=0 words=5", busy, rx_data.size() - rb);
        end else begin
            for (int k = 0; k < 5; k++) begin
                tests++;
                if (rx_data[rb+k] !== w[k] || rx_last[rb+k] !== (k == 4)) begin
                    fails++;
                    $display("FAIL uf_order%0d: got %h last=%b expected %h last=%b",
                             k, rx_data[rb+k], rx_last[rb+k], w[k], k == 4);
                end
            end
        end
        tests++;
        if (pop_cnt - pb !== 5 || done_cnt - db !== 1 || bad_en !== 0) begin
            fails++;
            $display("FAIL uf_counts: got pops=%0d dones=%0d empty_pops=%0d expected 5 1 0",
                     pop_cnt - pb, done_cnt - db, bad_en);
        end
    endtask

    task automatic test_illegal_len();
        logic [LW-1:0] lens [3];
        logic          abt  [3];
        int pb, db;
        lens = '{LW'(0), LW'(MB + 1), LW'(2)};
        abt  = '{1'b0, 1'b0, 1'b1};
        push(32'h3333_0001);
        push(32'h3333_0002);
        for (int k = 0; k < 3; k++) begin
            pb = pop_cnt; db = done_cnt;
            @(negedge clk); start = 1'b1; burst_len = lens[k]; abort = abt[k];
            @(negedge clk); start = 1'b0; abort = 1'b0;
            repeat (3) begin
                @(negedge clk);
                tests++;
                if (busy !== 1'b0 || fifo_read_en !== 1'b0) begin
                    fails++;
                    $display("FAIL illegal%0d: got busy=%b en=%b expected 0 0", k, busy, fifo_read_en);
                end
            end
            tests++;
            if (pop_cnt - pb !== 0 || done_cnt - db !== 0) begin
                fails++;
                $display("FAIL illegal%0d_counts: got pops=%0d dones=%0d expected 0 0", k, pop_cnt - pb, done_cnt - db);
            end
        end
        flush();
    endtask

    task automatic test_abort();
        logic [DW-1:0] w [6];
        int pb, db, rb;
        w = '{32'h4444_0000, 32'h4444_0001, 32'h4444_0002, 32'h4444_0003, 32'h4444_0004, 32'h4444_0005};
        for (int i = 0; i < 6; i++) push(w[i]);
        pb = pop_cnt; db = done_cnt; rb = rx_data.size();
        out_ready = 1'b1;
        @(negedge clk); start = 1'b1; burst_len = LW'(6);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_data !== w[1]) begin
            fails++;
            $display("FAIL ab_word2: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, w[1]);
        end
        abort = 1'b1; out_ready = 1'b0;
        #1;
        tests++;
        if (fifo_read_en !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL ab_suppress: got en=%b done=%b expected 0 0", fifo_read_en, done);
        end
        @(negedge clk); abort = 1'b0; out_ready = 1'b1;
        tests++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL ab_idle: got v=%b l=%b busy=%b expected 0 0 0", out_valid, out_last, busy);
        end
        tests++;
        if (pop_cnt - pb !== 2 || done_cnt - db !== 0) begin
            fails++;
            $display("FAIL ab_counts: got pops=%0d dones=%0d expected 2 0", pop_cnt - pb, done_cnt - db);
        end
        @(negedge clk); start = 1'b1; burst_len = LW'(2);
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);
        tests++;
        if (rx_data.size() - rb !== 3 || done_cnt - db !== 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL ab_next: got words=%0d dones=%0d busy=%b expected 3 1 0",
                     rx_data.size() - rb, done_cnt - db, busy);
        end else begin
            tests++;
            if (rx_data[rb] !== w[0] || rx_data[rb+1] !== w[2] || rx_data[rb+2] !== w[3] || rx_last[rb+2] !== 1'b1) begin
                fails++;
                $display("FAIL ab_next_data: got %h %h %h last=%b expected %h %h %h last=1",
                         rx_data[rb], rx_data[rb+1], rx_data[rb+2], rx_last[rb+2], w[0], w[2], w[3]);
            end
        end
        flush();
    endtask

    task automatic test_reset_mid();
        int pb, db;
        for (int i = 0; i < 4; i++) push(32'h5555_0000 + DW'(i));
        out_ready = 1'b1;
        @(negedge clk); start = 1'b1; burst_len = LW'(4);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_last, done, busy, fifo_read_en} !== 5'b0 || out_data !== '0) begin
            fails++;
            $display("FAIL rm_async: got v=%b l=%b d=%b b=%b en=%b data=%h expected all 0",
                     out_valid, out_last, done, busy, fifo_read_en, out_data);
        end
        pb = pop_cnt; db = done_cnt;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || pop_cnt - pb !== 0 || done_cnt - db !== 0) begin
            fails++;
            $display("FAIL rm_release: got busy=%b pops=%0d dones=%0d expected 0 0 0",
                     busy, pop_cnt - pb, done_cnt - db);
        end
        flush();
        test_basic("rm_burst");
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_backpressure();
        test_underflow();
        test_illegal_len();
        test_abort();
        test_reset_mid();
        tests++;
        if (bad_en !== 0) begin
            fails++;
            $display("FAIL pop_while_empty: got %0d expected 0", bad_en);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_fifo_burst_reader

`default_nettype wire
